// File: rtl/mau_pkg.sv
// Shared types, size codes and the alignment rule for the MEM-stage access unit.
package mau_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_RMW_RD = 3'd2,
      ST_STORE  = 3'd3,
      ST_RESP   = 3'd4
   } mau_state_e;

   localparam logic [1:0] SZ_BYTE    = 2'd0;
   localparam logic [1:0] SZ_HALF    = 2'd1;
   localparam logic [1:0] SZ_WORD    = 2'd2;
   localparam logic [1:0] SZ_ILLEGAL = 2'd3;

   // True when the access cannot be performed: an illegal size code, or a
   // halfword/word whose byte offset does not sit on its natural boundary.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addr_lo[0];
         SZ_WORD: bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response handshake plus the word-addressed data memory port.
// The slave modport is the access unit's view; master is the pipeline/memory side.
interface mem_access_unit_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;

   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;

   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_read;
   logic              mem_write;
   logic [31:0]       mem_rdata;

   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      input  mem_rdata,
      output req_ready,
      output rsp_valid, rsp_rdata, rsp_err,
      output mem_addr, mem_wdata, mem_read, mem_write
   );

   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      output mem_rdata,
      input  req_ready,
      input  rsp_valid, rsp_rdata, rsp_err,
      input  mem_addr, mem_wdata, mem_read, mem_write
   );

endinterface

// File: rtl/mem_access_unit_lane.sv
// Little-endian lane handling: pulls a byte/halfword out of a memory word and
// extends it, and splices store data into an existing word for sub-word writes.
module mau_lane
   import mau_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] new_data,
   output logic [31:0] ext_data,
   output logic [31:0] merged_data
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic        fill;

   // Select the addressed lane and widen it to 32 bits, replicating the lane's
   // top bit only for signed loads.
   always_comb begin
      lane_byte = 8'h00;
      lane_half = 16'h0000;
      fill      = 1'b0;
      ext_data  = word;
      case (addr_lo)
         2'd0:    lane_byte = word[7:0];
         2'd1:    lane_byte = word[15:8];
         2'd2:    lane_byte = word[23:16];
         default: lane_byte = word[31:24];
      endcase
      lane_half = addr_lo[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: begin
            fill     = sign_ext & lane_byte[7];
            ext_data = {{24{fill}}, lane_byte};
         end
         SZ_HALF: begin
            fill     = sign_ext & lane_half[15];
            ext_data = {{16{fill}}, lane_half};
         end
         default: ext_data = word;
      endcase
   end

   // Overwrite only the addressed lane of the old word with the low bits of the
   // store data; everything else in the word is preserved.
   always_comb begin
      merged_data = word;
      case (size)
         SZ_BYTE: begin
            case (addr_lo)
               2'd0:    merged_data[7:0]   = new_data[7:0];
               2'd1:    merged_data[15:8]  = new_data[7:0];
               2'd2:    merged_data[23:16] = new_data[7:0];
               default: merged_data[31:24] = new_data[7:0];
            endcase
         end
         SZ_HALF: begin
            if (addr_lo[1]) begin
               merged_data[31:16] = new_data[15:0];
            end else begin
               merged_data[15:0] = new_data[15:0];
            end
         end
         default: merged_data = new_data;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: accepts one request at a time, drives the
// word-addressed data memory, and returns an extended load result or an error.
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_access_unit_if.slave  bus
);

   mau_state_e        state_q,     state_d;
   logic [ADDR_W-1:0] addr_q,      addr_d;
   logic [1:0]        size_q,      size_d;
   logic              signed_q,    signed_d;
   logic              write_q,     write_d;
   logic [31:0]       wdata_q,     wdata_d;
   logic [31:0]       buf_q,       buf_d;
   logic [31:0]       rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q,   rsp_err_d;

   logic [31:0]       ext_data;
   logic [31:0]       merged_data;
   logic              mem_active;

   mau_lane u_lane (
      .word        (bus.mem_rdata),
      .addr_lo     (addr_q[1:0]),
      .size        (size_q),
      .sign_ext    (signed_q),
      .new_data    (wdata_q),
      .ext_data    (ext_data),
      .merged_data (merged_data)
   );

   // State register and request latches; reset drops the FSM to IDLE at once so
   // an in-progress memory write is withdrawn in the same instant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         size_q      <= 2'd0;
         signed_q    <= 1'b0;
         write_q     <= 1'b0;
         wdata_q     <= 32'd0;
         buf_q       <= 32'd0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         signed_q    <= signed_d;
         write_q     <= write_d;
         wdata_q     <= wdata_d;
         buf_q       <= buf_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Next-state logic: IDLE classifies the request, the memory states do one
   // access each, and the response registers only change on the way into RESP.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      size_d      = size_q;
      signed_d    = signed_q;
      write_d     = write_q;
      wdata_d     = wdata_q;
      buf_d       = buf_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               addr_d   = bus.req_addr;
               size_d   = bus.req_size;
               signed_d = bus.req_signed;
               write_d  = bus.req_write;
               wdata_d  = bus.req_wdata;
               if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
                  rsp_rdata_d = 32'd0;
                  rsp_err_d   = 1'b1;
                  state_d     = ST_RESP;
               end else if (!bus.req_write) begin
                  state_d = ST_LOAD;
               end else if (bus.req_size == SZ_WORD) begin
                  buf_d   = bus.req_wdata;
                  state_d = ST_STORE;
               end else begin
                  state_d = ST_RMW_RD;
               end
            end
         end
         ST_LOAD, ST_STORE: begin
            rsp_rdata_d = write_q ? 32'd0 : ext_data;
            rsp_err_d   = 1'b0;
            state_d     = ST_RESP;
         end
         ST_RMW_RD: begin
            buf_d   = merged_data;
            state_d = ST_STORE;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign mem_active    = (state_q == ST_LOAD) || (state_q == ST_RMW_RD) ||
                          (state_q == ST_STORE);

   assign bus.req_ready = (state_q == ST_IDLE);
   assign bus.rsp_valid = (state_q == ST_RESP);
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

   assign bus.mem_read  = (state_q == ST_LOAD) || (state_q == ST_RMW_RD);
   assign bus.mem_write = (state_q == ST_STORE);
   assign bus.mem_addr  = mem_active ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign bus.mem_wdata = (state_q == ST_STORE) ? buf_q : 32'd0;

endmodule
